// File: rtl/hack_decode_queue_if.sv
// hack_decode_queue_if: fetch-side and execute-side valid/ready handshakes of the Hack decode queue
interface hack_decode_queue_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_inst;
  logic        out_valid;
  logic        out_ready;
  logic        out_is_c;
  logic [14:0] out_a_value;
  logic        out_write_m;
  logic        out_load_d;
  logic        out_load_a;
  logic        out_sel_am;
  logic [5:0]  out_alu_ctrl;
  logic [2:0]  out_jump;
  logic        out_illegal;
  modport master (
    output in_valid, in_inst, out_ready,
    input  in_ready, out_valid, out_is_c, out_a_value, out_write_m, out_load_d,
           out_load_a, out_sel_am, out_alu_ctrl, out_jump, out_illegal
  );
  modport slave (
    input  in_valid, in_inst, out_ready,
    output in_ready, out_valid, out_is_c, out_a_value, out_write_m, out_load_d,
           out_load_a, out_sel_am, out_alu_ctrl, out_jump, out_illegal
  );
endinterface

// File: rtl/hack_decode_queue.sv
// hack_decode_queue: decodes Hack instructions at enqueue into a DEPTH-entry FIFO of control words (ports: clk, rst_n, flush, bus slave, count, illegal_cnt)
module hack_decode_queue #(
  parameter int DEPTH  = 4,
  parameter bit STRICT = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  hack_decode_queue_if.slave       bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         illegal_cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [29:0]      r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_count;
  logic [CNT_W-1:0] r_ill_cnt;
  logic             w_push;
  logic             w_pop;
  logic             w_is_c;
  logic             w_ill;
  logic             w_ok;
  logic [29:0]      w_word;
  logic [29:0]      w_head;
  assign w_is_c = bus.in_inst[15];
  assign w_ill  = STRICT && w_is_c && (bus.in_inst[14:13] != 2'b11);
  assign w_ok   = !w_ill;
  // word = {illegal, is_c, a_value, write_m, load_d, load_a, sel_am, alu_ctrl, jump}; illegal keeps alu/sel_am for debug
  assign w_word = w_is_c
    ? {w_ill, 1'b1, 15'd0, bus.in_inst[3] & w_ok, bus.in_inst[4] & w_ok, bus.in_inst[5] & w_ok,
       bus.in_inst[12], bus.in_inst[11:6], bus.in_inst[2:0] & {3{w_ok}}}
    : {2'b00, bus.in_inst[14:0], 3'b001, 1'b0, 6'd0, 3'd0};
  // DEPTH is a power of two and count never exceeds it, so the MSB alone means full
  assign bus.in_ready  = !r_count[AW];
  assign bus.out_valid = r_count != '0;
  assign w_push = bus.in_valid & bus.in_ready;
  assign w_pop  = bus.out_valid & bus.out_ready;
  assign w_head = bus.out_valid ? r_mem[r_rd] : '0;
  assign {bus.out_illegal, bus.out_is_c, bus.out_a_value, bus.out_write_m, bus.out_load_d,
          bus.out_load_a, bus.out_sel_am, bus.out_alu_ctrl, bus.out_jump} = w_head;
  assign count       = r_count;
  assign illegal_cnt = r_ill_cnt;
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= w_word;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr      <= '0;
      r_rd      <= '0;
      r_count   <= '0;
      r_ill_cnt <= '0;
    end else if (flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
      if (w_push && w_ill && r_ill_cnt != '1) r_ill_cnt <= r_ill_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_hack_decode_queue.sv
// tb_hack_decode_queue: directed checks of decode, FIFO order, full/flush/reset behaviour for strict and relaxed queues
module tb_hack_decode_queue;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_inst = '0;
  logic        out_ready = 1'b0;
  logic [2:0]  count1;
  logic [2:0]  count0;
  logic [15:0] ill1;
  logic [15:0] ill0;
  int          errors = 0;
  int          checks = 0;
  hack_decode_queue_if if1 ();
  hack_decode_queue_if if0 ();
  assign if1.in_valid  = in_valid;
  assign if1.in_inst   = in_inst;
  assign if1.out_ready = out_ready;
  assign if0.in_valid  = in_valid;
  assign if0.in_inst   = in_inst;
  assign if0.out_ready = out_ready;
  hack_decode_queue #(.DEPTH(4), .STRICT(1'b1), .CNT_W(16)) u_strict (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(if1), .count(count1), .illegal_cnt(ill1));
  hack_decode_queue #(.DEPTH(4), .STRICT(1'b0), .CNT_W(16)) u_relax (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(if0), .count(count0), .illegal_cnt(ill0));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [15:0] inst);
    in_valid = 1'b1;
    in_inst  = inst;
    tick();
    in_valid = 1'b0;
  endtask
  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask
  initial begin
    #3;
    chk("rst_valid", if1.out_valid, 0);
    chk("rst_count", count1, 0);
    chk("rst_illcnt", ill1, 0);
    chk("rst_a_value", if1.out_a_value, 0);
    #10 rst_n = 1'b1;
    tick();
    chk("rdy_after_rst", if1.in_ready, 1);
    push(16'h0015);
    chk("a_valid", if1.out_valid, 1);
    chk("a_is_c", if1.out_is_c, 0);
    chk("a_value", if1.out_a_value, 15'h0015);
    chk("a_load_a", if1.out_load_a, 1);
    chk("a_others", {if1.out_write_m, if1.out_load_d, if1.out_sel_am, if1.out_alu_ctrl, if1.out_jump, if1.out_illegal}, 0);
    chk("a_count", count1, 1);
    pop();
    chk("pop_count", count1, 0);
    chk("pop_valid", if1.out_valid, 0);
    push(16'hFC10);
    chk("dm_is_c", if1.out_is_c, 1);
    chk("dm_sel_am", if1.out_sel_am, 1);
    chk("dm_alu", if1.out_alu_ctrl, 6'b110000);
    chk("dm_wr_ld_la", {if1.out_write_m, if1.out_load_d, if1.out_load_a}, 3'b010);
    chk("dm_jump", if1.out_jump, 0);
    chk("dm_illegal", if1.out_illegal, 0);
    pop();
    push(16'hEA87);
    chk("jmp_alu", if1.out_alu_ctrl, 6'b101010);
    chk("jmp_jump", if1.out_jump, 3'b111);
    chk("jmp_wr_ld_la", {if1.out_write_m, if1.out_load_d, if1.out_load_a}, 0);
    chk("jmp_a_value", if1.out_a_value, 0);
    chk("jmp_sel_am", if1.out_sel_am, 0);
    pop();
    push(16'h8010);
    chk("ill_s_illegal", if1.out_illegal, 1);
    chk("ill_s_load_d", if1.out_load_d, 0);
    chk("ill_s_is_c", if1.out_is_c, 1);
    chk("ill_s_cnt", ill1, 1);
    chk("ill_r_illegal", if0.out_illegal, 0);
    chk("ill_r_load_d", if0.out_load_d, 1);
    chk("ill_r_cnt", ill0, 0);
    pop();
    chk("ill_popped", count1, 0);
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_inst = 16'(k + 1);
      tick();
      if (k == 3) begin
        chk("full_count4", count1, 4);
        chk("full_rdy", if1.in_ready, 0);
      end
    end
    chk("full_count5", count1, 4);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain_%0d", k), if1.out_a_value, k + 1);
      tick();
    end
    out_ready = 1'b0;
    chk("drain_count", count1, 0);
    push(16'h0AAA);
    push(16'h0BBB);
    in_valid  = 1'b1;
    in_inst   = 16'h0CCC;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("conc_count", count1, 2);
    chk("conc_head", if1.out_a_value, 15'h0BBB);
    tick();
    chk("conc_next", if1.out_a_value, 15'h0CCC);
    tick();
    out_ready = 1'b0;
    chk("conc_empty", count1, 0);
    push(16'h8000);
    push(16'h0001);
    push(16'h0002);
    chk("fl_pre_count", count1, 3);
    chk("fl_pre_cnt", ill1, 2);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_inst   = 16'h8010;
    out_ready = 1'b1;
    chk("fl_rdy_during", if1.in_ready, 1);
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("fl_count", count1, 0);
    chk("fl_valid", if1.out_valid, 0);
    chk("fl_cnt_kept", ill1, 2);
    push(16'h0033);
    chk("fl_after_head", if1.out_a_value, 15'h0033);
    push(16'h8001);
    chk("mid_count", count1, 2);
    chk("mid_cnt", ill1, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", if1.out_valid, 0);
    chk("arst_count", count1, 0);
    chk("arst_cnt", ill1, 0);
    chk("arst_a_value", if1.out_a_value, 0);
    #3 rst_n = 1'b1;
    tick();
    chk("arst_rdy", if1.in_ready, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
